// File: rtl/sram_arb_pkg.sv
// ---------------------------------------------------------------------------
// sram_arb_pkg : shared types and constants for the SRAM arbiter  (rev 1.0)
// ---------------------------------------------------------------------------
`default_nettype none

package sram_arb_pkg;

  localparam int ADDR_W_DEF = 20;
  localparam int DATA_W_DEF = 16;
  localparam int RD_SLOT    = 3;
  localparam int WR_SLOT    = 4;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_RD1  = 3'd1,
    ST_RD2  = 3'd2,
    ST_WR1  = 3'd3,
    ST_WR2  = 3'd4,
    ST_WR3  = 3'd5,
    ST_PARK = 3'd6
  } state_e;

  function automatic int cnt_width(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/sram_arb_prio.sv
// ---------------------------------------------------------------------------
// sram_arb_prio : read-priority grant select with write-starvation counter
// rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module sram_arb_prio
  import sram_arb_pkg::*;
#(
  parameter int WR_STARVE_MAX = 4
) (
  input  logic clk50,
  input  logic rst,
  input  logic rd_req,
  input  logic wr_req,
  input  logic idle,
  input  logic enable,
  output logic gnt_rd,
  output logic gnt_wr
);

  localparam int               CNT_W   = cnt_width(WR_STARVE_MAX);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(WR_STARVE_MAX);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             rd_allowed;

  always_comb begin
    // With WR_STARVE_MAX == 0 the compare is never true, so a pending write always wins
    rd_allowed = !wr_req || (cnt_q < CNT_MAX);
    gnt_rd     = idle && enable && rd_req && rd_allowed;
    gnt_wr     = idle && enable && wr_req && !gnt_rd;
    cnt_d      = cnt_q;
    if (gnt_wr) begin
      cnt_d = '0;
    end else if (gnt_rd) begin
      if (!wr_req) begin
        cnt_d = '0;
      end else if (cnt_q != CNT_MAX) begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk50) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

`default_nettype wire

// File: rtl/sram_arbiter.sv
// ---------------------------------------------------------------------------
// sram_arbiter : shares one async SRAM between scanout reads and draw writes
// rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module sram_arbiter
  import sram_arb_pkg::*;
#(
  parameter int ADDR_W        = ADDR_W_DEF,
  parameter int DATA_W        = DATA_W_DEF,
  parameter int WR_STARVE_MAX = 4
) (
  input  logic              clk50,
  input  logic              rst,
  input  logic              enable,
  input  logic              rd_req,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic              rd_ack,
  output logic              rd_data_valid,
  output logic [DATA_W-1:0] rd_data,
  input  logic              wr_req,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_ack,
  output logic [ADDR_W-1:0] SRAM_ADDR,
  inout  wire  [DATA_W-1:0] SRAM_DQ,
  output logic              SRAM_CE_N,
  output logic              SRAM_OE_N,
  output logic              SRAM_WE_N,
  output logic              SRAM_UB_N,
  output logic              SRAM_LB_N
);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] rd_data_q;
  logic              rd_ack_q, wr_ack_q, rd_valid_q;
  logic              ce_n_q, oe_n_q, we_n_q, dq_oe_q, pin_oe_q;
  logic              ce_n_d, oe_n_d, we_n_d, dq_oe_d, pin_oe_d;
  logic              gnt_rd, gnt_wr;

  sram_arb_prio #(
    .WR_STARVE_MAX(WR_STARVE_MAX)
  ) u_prio (
    .clk50 (clk50),
    .rst   (rst),
    .rd_req(rd_req),
    .wr_req(wr_req),
    .idle  (state_q == ST_IDLE),
    .enable(enable),
    .gnt_rd(gnt_rd),
    .gnt_wr(gnt_wr)
  );

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    case (state_q)
      ST_IDLE: begin
        if (!enable) begin
          state_d = ST_PARK;
        end else if (gnt_rd) begin
          state_d = ST_RD1;
          addr_d  = rd_addr;
        end else if (gnt_wr) begin
          state_d = ST_WR1;
          addr_d  = wr_addr;
          wdata_d = wr_data;
        end
      end
      ST_RD1:  state_d = ST_RD2;
      ST_RD2:  state_d = ST_IDLE;
      ST_WR1:  state_d = ST_WR2;
      ST_WR2:  state_d = ST_WR3;
      ST_WR3:  state_d = ST_IDLE;
      ST_PARK: if (enable) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    // Strobes are decoded from the next state so the pins change cleanly on the edge
    ce_n_d   = !(state_d inside {ST_RD1, ST_RD2, ST_WR1, ST_WR2, ST_WR3});
    oe_n_d   = !(state_d inside {ST_RD1, ST_RD2});
    we_n_d   = (state_d != ST_WR2);
    dq_oe_d  = (state_d inside {ST_WR1, ST_WR2, ST_WR3});
    pin_oe_d = (state_d != ST_PARK);
  end

  always_ff @(posedge clk50) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      addr_q     <= '0;
      wdata_q    <= '0;
      rd_data_q  <= '0;
      rd_ack_q   <= 1'b0;
      wr_ack_q   <= 1'b0;
      rd_valid_q <= 1'b0;
      ce_n_q     <= 1'b1;
      oe_n_q     <= 1'b1;
      we_n_q     <= 1'b1;
      dq_oe_q    <= 1'b0;
      pin_oe_q   <= 1'b1;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      rd_ack_q   <= (state_d == ST_RD1) && (state_q == ST_IDLE);
      wr_ack_q   <= (state_d == ST_WR1) && (state_q == ST_IDLE);
      rd_valid_q <= (state_q == ST_RD2);
      if (state_q == ST_RD2) begin
        rd_data_q <= SRAM_DQ;
      end
      ce_n_q     <= ce_n_d;
      oe_n_q     <= oe_n_d;
      we_n_q     <= we_n_d;
      dq_oe_q    <= dq_oe_d;
      pin_oe_q   <= pin_oe_d;
    end
  end

  assign rd_ack        = rd_ack_q;
  assign wr_ack        = wr_ack_q;
  assign rd_data_valid = rd_valid_q;
  assign rd_data       = rd_data_q;

  assign SRAM_ADDR = pin_oe_q ? addr_q  : {ADDR_W{1'bz}};
  assign SRAM_DQ   = dq_oe_q  ? wdata_q : {DATA_W{1'bz}};
  assign SRAM_CE_N = pin_oe_q ? ce_n_q  : 1'bz;
  assign SRAM_OE_N = pin_oe_q ? oe_n_q  : 1'bz;
  assign SRAM_WE_N = pin_oe_q ? we_n_q  : 1'bz;
  assign SRAM_UB_N = pin_oe_q ? 1'b0    : 1'bz;
  assign SRAM_LB_N = pin_oe_q ? 1'b0    : 1'bz;

endmodule

`default_nettype wire

// File: tb/tb_sram_arbiter.sv
// ---------------------------------------------------------------------------
// tb_sram_arbiter : directed bench with SRAM model and read-data scoreboard
// rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_sram_arbiter;
  import sram_arb_pkg::*;

  logic        clk50 = 1'b0;
  logic        rst = 1'b1;
  logic        enable = 1'b1;
  logic        rd_req = 1'b0;
  logic [19:0] rd_addr = '0;
  logic        rd_ack, rd_data_valid;
  logic [15:0] rd_data;
  logic        wr_req = 1'b0;
  logic [19:0] wr_addr = '0;
  logic [15:0] wr_data = '0;
  logic        wr_ack;

  // Pull-ups make a released pin read back as all ones
  tri1 [19:0] sram_addr;
  tri1 [15:0] sram_dq;
  tri1        sram_ce_n, sram_oe_n, sram_we_n, sram_ub_n, sram_lb_n;

  logic [15:0] mem [0:(1<<20)-1];
  logic [15:0] exp_q[$];
  int          total = 0;
  int          bad = 0;

  always #10 clk50 = ~clk50;

  sram_arbiter #(.ADDR_W(20), .DATA_W(16), .WR_STARVE_MAX(4)) dut (
    .clk50(clk50), .rst(rst), .enable(enable),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_ack(rd_ack),
    .rd_data_valid(rd_data_valid), .rd_data(rd_data),
    .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ack(wr_ack),
    .SRAM_ADDR(sram_addr), .SRAM_DQ(sram_dq), .SRAM_CE_N(sram_ce_n),
    .SRAM_OE_N(sram_oe_n), .SRAM_WE_N(sram_we_n), .SRAM_UB_N(sram_ub_n),
    .SRAM_LB_N(sram_lb_n)
  );

  assign sram_dq = (sram_ce_n === 1'b0 && sram_oe_n === 1'b0 && sram_we_n === 1'b1)
                   ? mem[sram_addr] : 16'hzzzz;

  always @(posedge clk50) begin
    if (sram_ce_n === 1'b0 && sram_we_n === 1'b0) mem[sram_addr] <= sram_dq;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk50);
  endtask

  always @(negedge clk50) begin
    if (!rst && rd_data_valid === 1'b1) begin
      if (exp_q.size() == 0) chk("rd_unexpected_valid", 32'd1, 32'd0);
      else chk("rd_data", {16'h0, rd_data}, {16'h0, exp_q.pop_front()});
    end
  end

  task automatic write_txn(input logic [19:0] a, input logic [15:0] d);
    wr_addr = a; wr_data = d; wr_req = 1'b1;
    step();
    chk("wr_ack", {31'h0, wr_ack}, 32'd1);
    chk("wr1_ce_we_oe", {29'h0, sram_ce_n, sram_we_n, sram_oe_n}, 32'b011);
    chk("wr1_addr", {12'h0, sram_addr}, {12'h0, a});
    chk("wr1_dq", {16'h0, sram_dq}, {16'h0, d});
    wr_req = 1'b0;
    step();
    chk("wr2_we_low", {30'h0, sram_ce_n, sram_we_n}, 32'b00);
    chk("wr2_addr_dq", {sram_addr[15:0], sram_dq}, {a[15:0], d});
    step();
    chk("wr3_we_high", {30'h0, sram_ce_n, sram_we_n}, 32'b01);
    chk("wr3_addr_dq", {sram_addr[15:0], sram_dq}, {a[15:0], d});
    step();
    chk("wr_idle_ce", {31'h0, sram_ce_n}, 32'd1);
    chk("wr_mem", {16'h0, mem[a]}, {16'h0, d});
  endtask

  task automatic read_txn(input logic [19:0] a, input logic [15:0] d);
    rd_addr = a; rd_req = 1'b1;
    step();
    chk("rd_ack", {31'h0, rd_ack}, 32'd1);
    exp_q.push_back(d);
    chk("rd1_ce_oe_we", {29'h0, sram_ce_n, sram_oe_n, sram_we_n}, 32'b001);
    chk("rd1_addr", {12'h0, sram_addr}, {12'h0, a});
    rd_req = 1'b0;
    step();
    chk("rd2_ack_valid", {30'h0, rd_ack, rd_data_valid}, 32'b00);
    step();
    chk("rd_valid_lat2", {31'h0, rd_data_valid}, 32'd1);
  endtask

  initial begin
    string glog;
    int    gcyc[$];
    int    cnt, found;

    mem[20'h12C3C] = 16'hBEEF;
    repeat (3) step();
    chk("rst_strobes", {29'h0, sram_ce_n, sram_oe_n, sram_we_n}, 32'b111);
    chk("rst_outs", {13'h0, rd_ack, wr_ack, rd_data_valid, rd_data}, 32'h0);
    rst = 1'b0;

    // Reset asserted in the middle of a write
    wr_addr = 20'h00055; wr_data = 16'h1234; wr_req = 1'b1;
    step();
    chk("pre_rst_wr1_dq", {16'h0, sram_dq}, 32'h1234);
    wr_req = 1'b0;
    step();
    chk("pre_rst_wr2_we", {31'h0, sram_we_n}, 32'd0);
    rst = 1'b1;
    step();
    chk("rst_wr_strobes", {29'h0, sram_ce_n, sram_oe_n, sram_we_n}, 32'b111);
    chk("rst_wr_dq_z", {16'h0, sram_dq}, 32'hFFFF);
    chk("rst_wr_outs", {13'h0, rd_ack, wr_ack, rd_data_valid, rd_data}, 32'h0);
    step(); step();
    rst = 1'b0;
    step();

    read_txn(20'h12C3C, 16'hBEEF);
    write_txn(20'h0B1E4, 16'hFFFF);
    write_txn(20'h00777, 16'h5A5A);
    read_txn(20'h00777, 16'h5A5A);
    step();

    // Both requesters held: reads win until the starvation guard forces a write
    rd_addr = 20'h00777; rd_req = 1'b1;
    wr_addr = 20'h00900; wr_data = 16'hC0DE; wr_req = 1'b1;
    glog = "";
    for (int c = 0; c < 60; c++) begin
      step();
      if (rd_ack === 1'b1) begin glog = {glog, "R"}; gcyc.push_back(c); exp_q.push_back(16'h5A5A); end
      if (wr_ack === 1'b1) begin glog = {glog, "W"}; gcyc.push_back(c); end
    end
    rd_req = 1'b0; wr_req = 1'b0;
    chk("starve_pattern", {31'h0, glog.substr(0, 9) == "RRRRWRRRRW"}, 32'd1);
    chk("rd_slot_len", (gcyc.size() > 5) ? gcyc[1] - gcyc[0] : -1, RD_SLOT);
    chk("wr_slot_len", (gcyc.size() > 5) ? gcyc[5] - gcyc[4] : -1, WR_SLOT);
    repeat (6) step();
    chk("starve_wr_mem", {16'h0, mem[20'h00900]}, 32'hC0DE);

    // enable dropped during RD1 with a write pending
    rd_addr = 20'h12C3C; rd_req = 1'b1;
    step();
    chk("en_rd_ack", {31'h0, rd_ack}, 32'd1);
    exp_q.push_back(16'hBEEF);
    enable = 1'b0; rd_req = 1'b0;
    wr_addr = 20'h00A00; wr_data = 16'h1111; wr_req = 1'b1;
    step();
    chk("en_rd2_oe", {31'h0, sram_oe_n}, 32'd0);
    step();
    chk("en_rd_valid", {31'h0, rd_data_valid}, 32'd1);
    step();
    chk("park_addr_z", {12'h0, sram_addr}, 32'hFFFFF);
    chk("park_dq_z", {16'h0, sram_dq}, 32'hFFFF);
    chk("park_ctrl_z", {27'h0, sram_ce_n, sram_oe_n, sram_we_n, sram_ub_n, sram_lb_n}, 32'h1F);
    for (int k = 0; k < 3; k++) begin
      step();
      chk("park_no_wr_ack", {31'h0, wr_ack}, 32'd0);
    end
    enable = 1'b1;
    cnt = 0; found = 0;
    for (int k = 0; k < 4 && found == 0; k++) begin
      step();
      cnt++;
      if (cnt == 1) chk("unpark_addr_driven", {12'h0, sram_addr}, 32'h12C3C);
      if (wr_ack === 1'b1) found = 1;
    end
    chk("unpark_wr_ack_lat", {31'h0, (found == 1 && cnt <= 2)}, 32'd1);
    wr_req = 1'b0;
    chk("unpark_wr_addr", {12'h0, sram_addr}, 32'h00A00);
    repeat (4) step();
    chk("unpark_wr_mem", {16'h0, mem[20'h00A00]}, 32'h1111);

    // Simultaneous requests with the counter cleared
    rd_addr = 20'h0B1E4; rd_req = 1'b1;
    wr_addr = 20'h00B00; wr_data = 16'h2222; wr_req = 1'b1;
    step();
    chk("simul_first_is_read", {30'h0, rd_ack, wr_ack}, 32'b10);
    exp_q.push_back(16'hFFFF);
    rd_req = 1'b0;
    cnt = 0; found = 0;
    for (int k = 0; k < 8 && found == 0; k++) begin
      step();
      cnt++;
      if (wr_ack === 1'b1) found = 1;
    end
    chk("simul_wr_after_rd_slot", found ? cnt : -1, RD_SLOT);
    wr_req = 1'b0;
    repeat (5) step();
    chk("simul_wr_mem", {16'h0, mem[20'h00B00]}, 32'h2222);
    chk("scoreboard_drained", exp_q.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1ms;
    $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire
